// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: segment patterns,
// conversion FSM encoding and the small combinational helpers both stages use.
package seven_seg_scanner_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } conv_state_e;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int unsigned BinW  = 8;
  localparam int unsigned BcdW  = 12;
  localparam logic [2:0]  LastIter = 3'd7;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

  // Double-dabble correction applied before each shift: any nibble >= 5 gets +3
  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd_in);
    logic [11:0] adj;
    adj = bcd_in;
    for (int i = 0; i < 3; i++) begin
      if (bcd_in[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_in[i*4 +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// Converts only when the input differs from the last captured value.
module bin2bcd8
  import seven_seg_scanner_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        busy
);

  conv_state_e state_q, state_d;
  logic [BinW-1:0] last_q, last_d;
  logic [BinW-1:0] bin_q, bin_d;
  logic [BcdW-1:0] scratch_q, scratch_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic [2:0]      iter_q, iter_d;
  logic [BcdW-1:0] scratch_adj;

  assign scratch_adj = dabble_adjust(scratch_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    unique case (state_q)
      StIdle: begin
        if (value != last_q) begin
          bin_d     = value;
          last_d    = value;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        // Shift {scratch, bin} left by one after the nibble correction
        {scratch_d, bin_d} = {scratch_adj[BcdW-2:0], bin_q, 1'b0};
        iter_d             = iter_q + 3'd1;
        if (iter_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = scratch_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q != StIdle);

endmodule

// File: rtl/seven_seg_scanner.sv
// Displays an 8-bit value as three decimal digits on a 4-anode common-anode
// display; the fourth slot is kept dark so every digit gets a 1/4 duty cycle.
module seven_seg_scanner #(
  parameter int unsigned scan_limit  = 100000,
  parameter bit          blank_zeros = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);
  import seven_seg_scanner_pkg::*;

  localparam int unsigned CntW = $clog2(scan_limit);
  localparam logic [CntW-1:0] CntMax = CntW'(scan_limit - 1);

  logic [11:0]     bcd_w;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      slot_q, slot_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic [3:0]      digit;
  logic            blank;

  bin2bcd8 u_bin2bcd8 (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .bcd   (bcd_w),
    .busy  (busy)
  );

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    slot_d = slot_q;
    if (cnt_q == CntMax) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
    end
  end

  // Output pattern for the current slot; registered below so seg/an move together
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    unique case (slot_q)
      2'd0: begin
        digit = bcd_w[3:0];
        an_d  = 4'hE;
      end
      2'd1: begin
        digit = bcd_w[7:4];
        blank = blank_zeros && (bcd_w[11:8] == 4'd0) && (bcd_w[7:4] == 4'd0);
        an_d  = 4'hD;
      end
      2'd2: begin
        digit = bcd_w[11:8];
        blank = blank_zeros && (bcd_w[11:8] == 4'd0);
        an_d  = 4'hB;
      end
      2'd3: begin
        blank = 1'b1;
        an_d  = 4'hF;
      end
      default: blank = 1'b1;
    endcase
    if (!blank) begin
      seg_d = seg_decode(digit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '0;
      seg_q  <= SEG_OFF;
      an_q   <= 4'hF;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;
  assign bcd = bcd_w;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: two instances (blanking on/off)
// share clock, reset and value; checks conversion timing, scanning and decode.
module tb_seven_seg_scanner;

  localparam int unsigned ScanLimit = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  value;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [3:0]  an, an_nb;
  logic [11:0] bcd, bcd_nb;
  logic        busy, busy_nb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  value;
    logic [11:0] bcd;
    logic [6:0]  s0, s1, s2;  // blanking on
    logic [6:0]  n1, n2;      // blanking off
  } vec_t;

  vec_t vecs[6];

  seven_seg_scanner #(
    .scan_limit  (ScanLimit),
    .blank_zeros (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy)
  );

  seven_seg_scanner #(
    .scan_limit  (ScanLimit),
    .blank_zeros (1'b0)
  ) u_dut_nb (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .seg   (seg_nb),
    .dp    (dp_nb),
    .an    (an_nb),
    .bcd   (bcd_nb),
    .busy  (busy_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic apply_and_wait(input logic [7:0] v);
    bit seen_busy;
    seen_busy = 1'b0;
    @(negedge clk);
    value = v;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) return;
    end
    check("conv_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [11:0] eb,
                             input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] n1, input logic [6:0] n2);
    logic [6:0] got[3];
    logic [6:0] got_nb[3];
    bit         seen[3];
    for (int i = 0; i < 3; i++) begin
      got[i] = 7'h55; got_nb[i] = 7'h55; seen[i] = 1'b0;
    end
    check({tag, "_bcd"}, 32'(bcd), 32'(eb));
    check({tag, "_bcd_nb"}, 32'(bcd_nb), 32'(eb));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check({tag, "_an_onehot"}, 32'($onehot(~an) || an == 4'hF), 32'd1);
      check({tag, "_an_nb_match"}, 32'(an_nb), 32'(an));
      case (an)
        4'hE: begin got[0] = seg; got_nb[0] = seg_nb; seen[0] = 1'b1; end
        4'hD: begin got[1] = seg; got_nb[1] = seg_nb; seen[1] = 1'b1; end
        4'hB: begin got[2] = seg; got_nb[2] = seg_nb; seen[2] = 1'b1; end
        4'hF: check({tag, "_dark_seg"}, 32'(seg), 32'h7F);
        default: ;
      endcase
    end
    check({tag, "_slots_seen"}, 32'({seen[2], seen[1], seen[0]}), 32'h7);
    check({tag, "_seg0"}, 32'(got[0]), 32'(e0));
    check({tag, "_seg1"}, 32'(got[1]), 32'(e1));
    check({tag, "_seg2"}, 32'(got[2]), 32'(e2));
    check({tag, "_nb_seg0"}, 32'(got_nb[0]), 32'(e0));
    check({tag, "_nb_seg1"}, 32'(got_nb[1]), 32'(n1));
    check({tag, "_nb_seg2"}, 32'(got_nb[2]), 32'(n2));
  endtask

  initial begin
    logic [3:0] walk[4];
    walk[0] = 4'hE; walk[1] = 4'hD; walk[2] = 4'hB; walk[3] = 4'hF;

    vecs[0] = '{value: 8'd255, bcd: 12'h255, s0: 7'h12, s1: 7'h12, s2: 7'h24, n1: 7'h12, n2: 7'h24};
    vecs[1] = '{value: 8'd7,   bcd: 12'h007, s0: 7'h78, s1: 7'h7F, s2: 7'h7F, n1: 7'h40, n2: 7'h40};
    vecs[2] = '{value: 8'd100, bcd: 12'h100, s0: 7'h40, s1: 7'h40, s2: 7'h79, n1: 7'h40, n2: 7'h79};
    vecs[3] = '{value: 8'd42,  bcd: 12'h042, s0: 7'h24, s1: 7'h19, s2: 7'h7F, n1: 7'h19, n2: 7'h40};
    vecs[4] = '{value: 8'd10,  bcd: 12'h010, s0: 7'h40, s1: 7'h79, s2: 7'h7F, n1: 7'h79, n2: 7'h40};
    vecs[5] = '{value: 8'd0,   bcd: 12'h000, s0: 7'h40, s1: 7'h7F, s2: 7'h7F, n1: 7'h40, n2: 7'h40};

    // Reset state
    rst = 1'b1;
    value = 8'd0;
    #12;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Conversion latency for 255: busy for 9 clks, bcd lands on the 10th edge
    @(negedge clk);
    value = 8'd255;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("lat255_busy_k%0d", k), 32'(busy), (k <= 9) ? 32'd1 : 32'd0);
      check($sformatf("lat255_bcd_k%0d", k), 32'(bcd), (k <= 9) ? 32'h000 : 32'h255);
    end
    check_frame("v255", 12'h255, 7'h12, 7'h12, 7'h24, 7'h12, 7'h24);

    // Asynchronous reset mid-run, away from any clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_seg", 32'(seg), 32'h7F);
    check("async_an", 32'(an), 32'hF);
    check("async_bcd", 32'(bcd), 32'h000);
    check("async_busy", 32'(busy), 32'h0);
    value = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_an", 32'(an), 32'hF);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("walk_an_k%0d", k), 32'(an), 32'(walk[(k - 1) / 4]));
      if (k > 12) check($sformatf("walk_dark_seg_k%0d", k), 32'(seg), 32'h7F);
    end

    // Table-driven values
    for (int i = 0; i < 6; i++) begin
      apply_and_wait(vecs[i].value);
      check_frame($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].s0, vecs[i].s1, vecs[i].s2,
                  vecs[i].n1, vecs[i].n2);
    end

    // Value change 3 clks into a conversion: 10 then 20, one idle clk between
    @(negedge clk);
    value = 8'd10;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) value = 8'd20;
      check($sformatf("chg_busy_k%0d", k), 32'(busy), (k == 10 || k == 20) ? 32'd0 : 32'd1);
      if (k == 9)  check("chg_bcd_k9", 32'(bcd), 32'h000);
      if (k == 10) check("chg_bcd_k10", 32'(bcd), 32'h010);
      if (k == 19) check("chg_bcd_k19", 32'(bcd), 32'h010);
      if (k == 20) check("chg_bcd_k20", 32'(bcd), 32'h020);
    end

    // Full sweep against the reference model
    for (int v = 0; v < 256; v++) begin
      int h, t, u;
      logic [6:0] e1, e2;
      h = v / 100; t = (v / 10) % 10; u = v % 10;
      e2 = (h == 0) ? 7'h7F : ref_seg(h);
      e1 = (h == 0 && t == 0) ? 7'h7F : ref_seg(t);
      apply_and_wait(8'(v));
      check_frame($sformatf("sweep%0d", v), {4'(h), 4'(t), 4'(u)}, ref_seg(u), e1, e2,
                  ref_seg(t), ref_seg(h));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
